// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM states, oversampling
// constants and the baud divider calculation.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } state_e;

   localparam int         OVERSAMPLE   = 16;
   localparam logic [3:0] SAMPLE_POINT = 4'd7;

   // Clocks per oversample tick, truncated.
   function automatic int calc_div(input int clk_hz, input int baud);
      return clk_hz / (baud * OVERSAMPLE);
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side link bundle: serial line in, byte and status pulses out.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

   // Receiver side.
   modport master (
      input  rx,
      output data, valid, frame_err, busy
`ifdef UART_RX_PARITY_EN
      , output parity_err
`endif
   );

   // Line driver / byte consumer side.
   modport slave (
      output rx,
      input  data, valid, frame_err, busy
`ifdef UART_RX_PARITY_EN
      , input  parity_err
`endif
   );
endinterface

// File: rtl/uart_rx_tick.sv
// Free-running oversample tick divider: one-cycle tick every DIV clocks,
// phase restarted synchronously by restart_i.
module uart_rx_tick #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic restart_i,
   output logic tick_o
);
   localparam int             W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0]   LAST = W'(DIV - 1);

   logic [W-1:0] cnt_q;

   // Count 0..DIV-1, restarting at zero on request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else if (restart_i || cnt_q == LAST)
         cnt_q <= '0;
      else
         cnt_q <= cnt_q + W'(1);
   end

   assign tick_o = (cnt_q == LAST) && !restart_i;
endmodule

// File: rtl/uart_rx.sv
// 8-bit LSB-first UART receiver, 16x oversampled, one stop bit.
// Define UART_RX_PARITY_EN for an even-parity bit between data and stop.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 115200
) (
   input  logic      clk,
   input  logic      rst,
   uart_rx_if.master bus
);
   localparam int DIV = calc_div(CLK_HZ, BAUD);

   generate
      if (DIV < 1) begin : g_div_check
         $error("uart_rx: CLK_HZ too low for BAUD with 16x oversampling");
      end
   endgenerate

   logic       rx_meta_q, rx_sync_q, rx_prev_q;
   logic       fall, tick, center, restart;
   state_e     state_q, state_d;
   logic [3:0] tick_cnt_q, tick_cnt_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       frame_err_q, frame_err_d;
   logic       busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
   logic       par_bad_q, par_bad_d;
   logic       parity_err_q, parity_err_d;
`endif

   uart_rx_tick #(.DIV(DIV)) u_tick (
      .clk       (clk),
      .rst       (rst),
      .restart_i (restart),
      .tick_o    (tick)
   );

   // Two-flop synchronizer plus a delayed copy for edge detection; idle high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= bus.rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   assign fall   = rx_prev_q && !rx_sync_q;
   assign center = tick && (tick_cnt_q == SAMPLE_POINT);

   // Next-state logic: frame sequencing, bit sampling and status pulses.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // can leave one unassigned and infer a latch.
      state_d     = state_q;
      tick_cnt_d  = tick_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
      busy_d      = busy_q;
      restart     = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d    = par_bad_q;
      parity_err_d = 1'b0;
`endif
      // Tick count wraps 15 -> 0, so the sample point recurs every bit.
      if (tick && state_q != IDLE && state_q != BREAK)
         tick_cnt_d = tick_cnt_q + 4'd1;

      case (state_q)
         IDLE: begin
            if (fall) begin
               state_d    = START;
               tick_cnt_d = 4'd0;
               bit_cnt_d  = 3'd0;
               restart    = 1'b1;
            end
         end
         START: begin
            if (center) begin
               if (!rx_sync_q) begin
                  state_d = DATA;
                  busy_d  = 1'b1;
               end else begin
                  state_d = IDLE;   // glitch: no outputs
               end
            end
         end
         DATA: begin
            if (center) begin
               shift_d   = {rx_sync_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (center) begin
               par_bad_d = ^{shift_q, rx_sync_q};   // even parity: total ones even
               state_d   = STOP;
            end
         end
`endif
         STOP: begin
            if (center) begin
               busy_d = 1'b0;
               if (rx_sync_q) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                  parity_err_d = par_bad_q;
`endif
                  state_d = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = BREAK;
               end
            end
         end
         BREAK: begin
            if (rx_sync_q)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset discards any partial frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         tick_cnt_q  <= 4'd0;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'h00;
         data_q      <= 8'h00;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register updates from
         // the same pre-edge values, independent of statement order.
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign bus.data      = data_q;
   assign bus.valid     = valid_q;
   assign bus.frame_err = frame_err_q;
   assign bus.busy      = busy_q;
`ifdef UART_RX_PARITY_EN
   assign bus.parity_err = parity_err_q;
`endif
endmodule
